// File: rtl/ppm_freq_recovery.sv
// Chip-rate frequency-recovery monitor for the 16-PPM SPAD receiver.
// Detects pulses per chip, measures the spacing between pulses and counts
// pulses per symbol window. Measurement is frozen while freq_ok is high.
module ppm_freq_recovery #(
  parameter  int SYMBOL_CHIPS = 16,
  parameter  int CHIP_BITS    = 1,
  localparam int SW           = $clog2(SYMBOL_CHIPS),
  localparam int IW           = SYMBOL_CHIPS + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHIP_BITS-1:0] din,
  input  logic [CHIP_BITS-1:0] pulse_threshold,
  input  logic                 freq_ok,
  output logic [IW-1:0]        interpulse_cycles,
  output logic [1:0]           intrasymbol_pulses,
  output logic [1:0]           FREQ_state_SC,
  output logic [1:0]           FREQ_next_state_SC,
  output logic [1:0]           FREQ_intrasymbol_pulse_count_SC,
  output logic [SW-1:0]        FREQ_symbol_cycle_count_SC,
  output logic [IW-1:0]        FREQ_interpulse_cycle_count_SC,
  output logic                 FREQ_max_symbol_cycle_count_SC,
  output logic                 FREQ_max_interpulse_cycle_count_SC,
  output logic                 FREQ_increment_symbol_cycle_count_SC,
  output logic                 FREQ_increment_interpulse_cycles_SC,
  output logic                 FREQ_pulse_detected_SC
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT    = 2'b01,
    TRACK   = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sym_q, sym_d;
  logic [1:0]    pc_q, pc_d;
  logic [IW-1:0] ipc_q, ipc_d;
  logic [IW-1:0] ipcyc_q, ipcyc_d;
  logic [1:0]    isp_q, isp_d;

  logic          pulse, sym_max, ipc_max, inc_sym, inc_ipc;
  logic [2:0]    pc_sum;
  logic [1:0]    pc_sat;

  assign pulse   = (din >= pulse_threshold);
  assign sym_max = (sym_q == SW'(SYMBOL_CHIPS - 1));
  assign ipc_max = &ipc_q;
  // Window pulse count including this chip, clamped at 3.
  assign pc_sum  = {1'b0, pc_q} + {2'b00, pulse};
  assign pc_sat  = pc_sum[2] ? 2'd3 : pc_sum[1:0];

  // Next-state and counter update; freq_ok freezes every counter and output.
  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    ipcyc_d = ipcyc_q;
    isp_d   = isp_q;
    inc_sym = 1'b0;
    inc_ipc = 1'b0;
    if (freq_ok) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: begin
          // First pulse opens the first window; no result is published yet.
          if (pulse) begin
            state_d = TRACK;
            ipc_d   = IW'(1);
            sym_d   = SW'(1);
            pc_d    = 2'd1;
          end
        end
        TRACK: begin
          if (pulse) begin
            ipcyc_d = ipc_q;
            ipc_d   = IW'(1);
          end else if (!ipc_max) begin
            ipc_d   = ipc_q + IW'(1);
            inc_ipc = 1'b1;
          end
          // A pulse on the last chip still belongs to the closing window.
          if (sym_max) begin
            isp_d = pc_sat;
            sym_d = '0;
            pc_d  = 2'd0;
          end else begin
            sym_d   = sym_q + SW'(1);
            pc_d    = pc_sat;
            inc_sym = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sym_q   <= '0;
      pc_q    <= 2'd0;
      ipc_q   <= '0;
      ipcyc_q <= '0;
      isp_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      ipcyc_q <= ipcyc_d;
      isp_q   <= isp_d;
    end
  end

  assign interpulse_cycles                    = ipcyc_q;
  assign intrasymbol_pulses                   = isp_q;
  assign FREQ_state_SC                        = state_q;
  assign FREQ_next_state_SC                   = state_d;
  assign FREQ_intrasymbol_pulse_count_SC      = pc_q;
  assign FREQ_symbol_cycle_count_SC           = sym_q;
  assign FREQ_interpulse_cycle_count_SC       = ipc_q;
  assign FREQ_max_symbol_cycle_count_SC       = sym_max;
  assign FREQ_max_interpulse_cycle_count_SC   = ipc_max;
  assign FREQ_increment_symbol_cycle_count_SC = inc_sym;
  assign FREQ_increment_interpulse_cycles_SC  = inc_ipc;
  assign FREQ_pulse_detected_SC               = pulse;

endmodule

// File: tb/tb_ppm_freq_recovery.sv
// Directed bench: a 16-chip, 2-bit DUT for the main behaviour and a 4-chip
// DUT so interpulse saturation (31) is reached in a few dozen cycles.
module tb_ppm_freq_recovery;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   total = 0;
  int   bad   = 0;

  // ---- main DUT: SYMBOL_CHIPS=16, CHIP_BITS=2
  logic [1:0]  din, thr;
  logic        fok;
  logic [16:0] ipcyc, ipc;
  logic [1:0]  isp, st, nst, pc;
  logic [3:0]  sym;
  logic        max_sym, max_ipc, inc_sym, inc_ipc, pdet;

  ppm_freq_recovery #(.SYMBOL_CHIPS(16), .CHIP_BITS(2)) u_dut (
    .clk(clk), .reset(reset), .din(din), .pulse_threshold(thr), .freq_ok(fok),
    .interpulse_cycles(ipcyc), .intrasymbol_pulses(isp),
    .FREQ_state_SC(st), .FREQ_next_state_SC(nst),
    .FREQ_intrasymbol_pulse_count_SC(pc), .FREQ_symbol_cycle_count_SC(sym),
    .FREQ_interpulse_cycle_count_SC(ipc),
    .FREQ_max_symbol_cycle_count_SC(max_sym),
    .FREQ_max_interpulse_cycle_count_SC(max_ipc),
    .FREQ_increment_symbol_cycle_count_SC(inc_sym),
    .FREQ_increment_interpulse_cycles_SC(inc_ipc),
    .FREQ_pulse_detected_SC(pdet));

  // ---- small DUT: SYMBOL_CHIPS=4, CHIP_BITS=1 (interpulse max = 31)
  logic       s_din, s_thr, s_fok;
  logic [4:0] s_ipcyc, s_ipc;
  logic [1:0] s_isp, s_st, s_nst, s_pc, s_sym;
  logic       s_max_sym, s_max_ipc, s_inc_sym, s_inc_ipc, s_pdet;

  ppm_freq_recovery #(.SYMBOL_CHIPS(4), .CHIP_BITS(1)) u_small (
    .clk(clk), .reset(reset), .din(s_din), .pulse_threshold(s_thr), .freq_ok(s_fok),
    .interpulse_cycles(s_ipcyc), .intrasymbol_pulses(s_isp),
    .FREQ_state_SC(s_st), .FREQ_next_state_SC(s_nst),
    .FREQ_intrasymbol_pulse_count_SC(s_pc), .FREQ_symbol_cycle_count_SC(s_sym),
    .FREQ_interpulse_cycle_count_SC(s_ipc),
    .FREQ_max_symbol_cycle_count_SC(s_max_sym),
    .FREQ_max_interpulse_cycle_count_SC(s_max_ipc),
    .FREQ_increment_symbol_cycle_count_SC(s_inc_sym),
    .FREQ_increment_interpulse_cycles_SC(s_inc_ipc),
    .FREQ_pulse_detected_SC(s_pdet));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic [1:0] d);
    din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sstep(input logic d);
    s_din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; fok = 1'b1; din = 2'd0; thr = 2'd1;
    s_fok = 1'b1; s_din = 1'b0; s_thr = 1'b1;
    #12;
    chk("rst_state", 32'(st), 0);
    chk("rst_ipcyc", 32'(ipcyc), 0);
    chk("rst_isp",   32'(isp), 0);
    chk("rst_ipc",   32'(ipc), 0);
    chk("rst_sym",   32'(sym), 0);
    @(negedge clk) reset = 1'b0;

    // frozen in IDLE regardless of din
    for (int i = 0; i < 20; i++) begin
      step(2'($urandom_range(0, 3)));
      chk("frz_state", 32'(st), 0);
      chk("frz_ipcyc", 32'(ipcyc), 0);
      chk("frz_isp",   32'(isp), 0);
    end

    // one pulse every 16 chips
    fok = 1'b0;
    step(0); chk("to_wait", 32'(st), 1);
    step(0); chk("wait_sym", 32'(sym), 0);
    step(1);
    chk("first_state", 32'(st), 2);
    chk("first_ipc",   32'(ipc), 1);
    chk("first_sym",   32'(sym), 1);
    chk("first_pc",    32'(pc), 1);
    chk("first_ipcyc", 32'(ipcyc), 0);
    chk("first_isp",   32'(isp), 0);
    for (int p = 0; p < 4; p++) begin
      repeat (14) step(0);
      chk("p16_sym15",   32'(sym), 15);
      chk("p16_maxsym",  32'(max_sym), 1);
      chk("p16_incsym",  32'(inc_sym), 0);
      chk("p16_incipc",  32'(inc_ipc), 1);
      step(0);
      chk("p16_wrap",    32'(sym), 0);
      chk("p16_isp",     32'(isp), 1);
      chk("p16_ipc",     32'(ipc), 16);
      step(1);
      chk("p16_ipcyc",   32'(ipcyc), 16);
      chk("p16_ipcrst",  32'(ipc), 1);
    end

    // pulses at window offsets 0 and 8
    for (int r = 0; r < 3; r++) begin
      repeat (7) step(0);
      step(1);
      chk("p8a_ipcyc", 32'(ipcyc), 8);
      chk("p8a_sym",   32'(sym), 9);
      repeat (7) step(0);
      chk("p8_wrap",   32'(sym), 0);
      chk("p8_isp",    32'(isp), 2);
      step(1);
      chk("p8b_ipcyc", 32'(ipcyc), 8);
    end

    // continuous pulses
    repeat (32) step(1);
    chk("cont_ipcyc",  32'(ipcyc), 1);
    chk("cont_isp",    32'(isp), 3);
    chk("cont_ipc",    32'(ipc), 1);
    chk("cont_incipc", 32'(inc_ipc), 0);

    // threshold 2 on 2-bit counts
    thr = 2'd2;
    din = 2'd1; #1 chk("thr_d1", 32'(pdet), 0);
    din = 2'd2; #1 chk("thr_d2", 32'(pdet), 1);
    din = 2'd3; #1 chk("thr_d3", 32'(pdet), 1);
    din = 2'd0; #1 chk("thr_d0", 32'(pdet), 0);

    fok = 1'b1; step(0); chk("lock_idle", 32'(st), 0);
    fok = 1'b0; step(0); chk("relock_wait", 32'(st), 1);
    step(1); chk("d1_ignored", 32'(st), 1);
    step(2);
    chk("t2_state", 32'(st), 2);
    chk("t2_sym",   32'(sym), 1);
    step(1);
    chk("t2_ipc",   32'(ipc), 2);
    chk("t2_pc",    32'(pc), 1);
    step(3);
    chk("t2_ipcyc", 32'(ipcyc), 2);
    chk("t2_pc2",   32'(pc), 2);
    chk("t2_sym3",  32'(sym), 3);

    // raise freq_ok mid-window
    fok = 1'b1; #1;
    chk("frz_incsym", 32'(inc_sym), 0);
    chk("frz_next",   32'(nst), 0);
    repeat (3) step(3);
    chk("hold_state", 32'(st), 0);
    chk("hold_sym",   32'(sym), 3);
    chk("hold_pc",    32'(pc), 2);
    chk("hold_ipc",   32'(ipc), 1);
    chk("hold_ipcyc", 32'(ipcyc), 2);
    chk("hold_isp",   32'(isp), 3);

    // re-enter: partial counts discarded on the next first pulse
    fok = 1'b0;
    step(1); chk("re_wait", 32'(st), 1);
    step(1); chk("re_hold_sym", 32'(sym), 3);
    step(2);
    chk("re_sym",   32'(sym), 1);
    chk("re_pc",    32'(pc), 1);
    chk("re_ipc",   32'(ipc), 1);
    chk("re_ipcyc", 32'(ipcyc), 2);
    step(2);
    chk("re_ipcyc1", 32'(ipcyc), 1);

    // async reset mid-TRACK
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_state", 32'(st), 0);
    chk("mid_rst_sym",   32'(sym), 0);
    chk("mid_rst_ipcyc", 32'(ipcyc), 0);
    chk("mid_rst_isp",   32'(isp), 0);
    @(negedge clk) reset = 1'b0;

    // interpulse saturation on the small DUT
    s_fok = 1'b0;
    sstep(0); chk("s_wait", 32'(s_st), 1);
    sstep(1); chk("s_track", 32'(s_st), 2);
    repeat (3) sstep(0);
    chk("s_isp1", 32'(s_isp), 1);
    repeat (4) sstep(0);
    chk("s_isp0", 32'(s_isp), 0);
    chk("s_ipc8", 32'(s_ipc), 8);
    repeat (33) sstep(0);
    chk("s_ipc_sat", 32'(s_ipc), 31);
    chk("s_max_ipc", 32'(s_max_ipc), 1);
    chk("s_inc_ipc", 32'(s_inc_ipc), 0);
    sstep(1);
    chk("s_ipcyc_sat", 32'(s_ipcyc), 31);
    chk("s_ipc_reload", 32'(s_ipc), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
